sseg_scan_mux: RTL and testbench

Parametrised, time-multiplexed seven-segment display driver for DIGITS common-anode digits. It is the generalised successor of our fixed four-digit scan logic and sits between any value-producing datapath (counters, switch readback) and the board SSEG/DP/AN pins.
- Adds tear-free frame-synchronous value loading.
- Adds per-digit decimal points, PWM brightness and a blank control.
- Includes hex segment decode internally.

---
 rtl/sseg_scan_mux.sv | 125 ++++++++++++
 tb/tb_sseg_scan_mux.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sseg_scan_mux.sv
// Time-multiplexed hex seven-segment driver: frame-synchronous loading, per-digit dp, PWM brightness, blank.
// Optional LEADING_ZERO_BLANK_EN hides leading zero digits (digit 0 always shown).
module sseg_scan_mux #(
  parameter int DIGITS       = 4,
  parameter int REFRESH_BITS = 17
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic [3:0]            bright,
  input  logic                  blank,
  output logic [6:0]            sseg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  pending,
  output logic                  frame_tick
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  logic [REFRESH_BITS-1:0] dwell;
  logic [IW-1:0]           idx;
  logic [4*DIGITS-1:0]     stage_val, disp_val;
  logic [DIGITS-1:0]       stage_dp, disp_dp;
  logic                    dwell_end, boundary;
  logic [3:0]              cur_nib;
  logic                    cur_dp, cur_sup, pwm_on, lit;
  logic [DIGITS-1:0]       an_sel;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  assign dwell_end  = &dwell;
  assign boundary   = dwell_end && (idx == LAST);
  assign frame_tick = boundary && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      dwell <= '0;
      idx   <= '0;
    end else begin
      dwell <= dwell + 1'b1;
      if (dwell_end)
        idx <= (idx == LAST) ? '0 : idx + 1'b1;
    end
  end

  // Display registers only move at a frame boundary; a load landing on the
  // boundary itself bypasses staging so it is not delayed a whole frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      stage_val <= '0;
      stage_dp  <= '0;
      disp_val  <= '0;
      disp_dp   <= '0;
      pending   <= 1'b0;
    end else if (boundary) begin
      if (load) begin
        disp_val <= value;
        disp_dp  <= dp_in;
      end else if (pending) begin
        disp_val <= stage_val;
        disp_dp  <= stage_dp;
      end
      pending <= 1'b0;
    end else if (load) begin
      stage_val <= value;
      stage_dp  <= dp_in;
      pending   <= 1'b1;
    end
  end

  always_comb begin
    cur_nib = '0;
    cur_dp  = 1'b0;
    cur_sup = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_nib = disp_val[4*i +: 4];
        cur_dp  = disp_dp[i];
`ifdef LEADING_ZERO_BLANK_EN
        cur_sup = (i > 0) && ((disp_val >> (4*i)) == '0);
`endif
      end
    end
  end

  assign pwm_on = dwell[REFRESH_BITS-1 -: 4] <= bright;
  assign lit    = pwm_on && !blank && !cur_sup;
  assign an_sel = ~(DIGITS'(1) << idx);

  always_ff @(posedge clk) begin
    if (reset) begin
      an   <= '1;
      sseg <= 7'h7F;
      dp   <= 1'b1;
    end else begin
      an   <= lit ? an_sel : '1;
      sseg <= cur_sup ? 7'h7F : hex7(cur_nib);
      dp   <= !(lit && cur_dp);
    end
  end

endmodule

// File: tb/tb_sseg_scan_mux.sv
// Bench for sseg_scan_mux (DIGITS=4, REFRESH_BITS=4): cycle model feeding a scoreboard, decode table, corner sequences.
module tb_sseg_scan_mux;
  logic        clk = 1'b0;
  logic        reset, load, blank;
  logic [15:0] value;
  logic [3:0]  dp_in, bright;
  logic [6:0]  sseg;
  logic        dp, pending, frame_tick;
  logic [3:0]  an;

  always #5 clk = ~clk;

  sseg_scan_mux #(.DIGITS(4), .REFRESH_BITS(4)) dut (
    .clk(clk), .reset(reset), .value(value), .dp_in(dp_in), .load(load),
    .bright(bright), .blank(blank), .sseg(sseg), .dp(dp), .an(an),
    .pending(pending), .frame_tick(frame_tick)
  );

  typedef struct { logic [3:0] nib; logic [6:0] seg; } vec_t;
  typedef struct { logic [3:0] an; logic [6:0] sseg; logic dp; } out_t;
  vec_t tab[16];
  out_t sbq[$];

  int checks = 0, failures = 0;
  int m_cnt = 0, m_idx = 0;
  logic [15:0] m_disp = '0, m_stage = '0;
  logic [3:0]  m_dpd = '0, m_dps = '0;
  logic        m_pend = 1'b0;
  logic [3:0]  obs_an;
  logic [6:0]  obs_sseg;
  logic        obs_dp;
  int low_cnt[4];
  int ft_cnt;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic out_t expect_out();
    out_t o;
    logic on, sup;
    logic [3:0] nib;
    nib = m_disp[m_idx*4 +: 4];
    sup = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    sup = (m_idx > 0) && ((m_disp >> (4*m_idx)) == 16'h0);
`endif
    on = !blank && (m_cnt <= int'(bright)) && !sup;
    if (reset) begin
      o.an = 4'hF; o.sseg = 7'h7F; o.dp = 1'b1;
    end else begin
      o.an   = on ? ~(4'b0001 << m_idx) : 4'hF;
      o.sseg = sup ? 7'h7F : tab[nib].seg;
      o.dp   = !(on && m_dpd[m_idx]);
    end
    return o;
  endfunction

  function automatic logic at_boundary();
    return (m_cnt == 15) && (m_idx == 3);
  endfunction

  task automatic clr_counts();
    for (int i = 0; i < 4; i++) low_cnt[i] = 0;
    ft_cnt = 0;
  endtask

  // One clock: pre-edge checks, push expectation, edge, pop/compare, advance model.
  task automatic step();
    logic bnd, r, l;
    logic [15:0] v;
    logic [3:0] dpi;
    out_t g;
    bnd = at_boundary();
    chk("frame_tick", {15'd0, frame_tick}, {15'd0, bnd && !reset});
    chk("pending", {15'd0, pending}, {15'd0, m_pend});
    if (frame_tick === 1'b1) ft_cnt++;
    sbq.push_back(expect_out());
    r = reset; l = load; v = value; dpi = dp_in;
    @(posedge clk);
    #1;
    g = sbq.pop_front();
    chk("an", {12'd0, an}, {12'd0, g.an});
    chk("sseg", {9'd0, sseg}, {9'd0, g.sseg});
    chk("dp", {15'd0, dp}, {15'd0, g.dp});
    obs_an = an; obs_sseg = sseg; obs_dp = dp;
    for (int i = 0; i < 4; i++) if (an[i] === 1'b0) low_cnt[i]++;
    if (r) begin
      m_cnt = 0; m_idx = 0; m_disp = '0; m_stage = '0;
      m_dpd = '0; m_dps = '0; m_pend = 1'b0;
    end else begin
      if (bnd) begin
        if (l) begin m_disp = v; m_dpd = dpi; end
        else if (m_pend) begin m_disp = m_stage; m_dpd = m_dps; end
        m_pend = 1'b0;
      end else if (l) begin
        m_stage = v; m_dps = dpi; m_pend = 1'b1;
      end
      if (m_cnt == 15) m_idx = (m_idx + 1) % 4;
      m_cnt = (m_cnt + 1) % 16;
    end
    @(negedge clk);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic to_boundary();
    int k;
    k = 0;
    while (!at_boundary() && k < 200) begin
      step();
      k++;
    end
    chk("boundary_reached", {15'd0, at_boundary()}, 16'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int bad;
    tab[0]  = '{4'h0, 7'b1000000}; tab[1]  = '{4'h1, 7'b1111001};
    tab[2]  = '{4'h2, 7'b0100100}; tab[3]  = '{4'h3, 7'b0110000};
    tab[4]  = '{4'h4, 7'b0011001}; tab[5]  = '{4'h5, 7'b0010010};
    tab[6]  = '{4'h6, 7'b0000010}; tab[7]  = '{4'h7, 7'b1111000};
    tab[8]  = '{4'h8, 7'b0000000}; tab[9]  = '{4'h9, 7'b0010000};
    tab[10] = '{4'hA, 7'b0001000}; tab[11] = '{4'hB, 7'b0000011};
    tab[12] = '{4'hC, 7'b1000110}; tab[13] = '{4'hD, 7'b0100001};
    tab[14] = '{4'hE, 7'b0000110}; tab[15] = '{4'hF, 7'b0001110};
    clr_counts();
    reset = 1'b1; load = 1'b0; blank = 1'b0; value = '0; dp_in = '0; bright = 4'd15;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset held 3 cycles mid-scan, then scan resumes from digit 0 showing 0.
    steps(37);
    reset = 1'b1;
    steps(3);
    chk("rst_an", {12'd0, an}, 16'h000F);
    chk("rst_sseg", {9'd0, sseg}, 16'h007F);
    chk("rst_dp", {15'd0, dp}, 16'd1);
    chk("rst_pending", {15'd0, pending}, 16'd0);
    reset = 1'b0;
    step();
    chk("first_an", {12'd0, obs_an}, 16'h000E);
    chk("first_sseg", {9'd0, obs_sseg}, 16'h0040);
    steps(16);
    chk("second_an", {12'd0, obs_an}, 16'h000D);

    // Load 12AF at frame cycle 10; pending until boundary, then F,A,2,1.
    to_boundary();
    step();
    steps(10);
    value = 16'h12AF; dp_in = 4'b0100; load = 1'b1;
    step();
    load = 1'b0;
    chk("pend_set", {15'd0, pending}, 16'd1);
    to_boundary();
    chk("pend_held", {15'd0, pending}, 16'd1);
    step();
    chk("pend_clr", {15'd0, pending}, 16'd0);
    clr_counts();
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      step();
      if (i == 0)  chk("dig0_F", {9'd0, obs_sseg}, 16'h000E);
      if (i == 16) chk("dig1_A", {9'd0, obs_sseg}, 16'h0008);
      if (i == 32) chk("dig2_2", {9'd0, obs_sseg}, 16'h0024);
      if (i == 48) chk("dig3_1", {9'd0, obs_sseg}, 16'h0079);
      if (obs_dp === 1'b0 && obs_an !== 4'b1011) bad++;
      if (obs_dp === 1'b0) ft_cnt += 0;
    end
    chk("dp_only_d2", bad[15:0], 16'd0);

    // Two loads in one frame: only the last reaches the display.
    steps(5);
    value = 16'h1111; load = 1'b1; step();
    value = 16'h2222; step();
    load = 1'b0;
    to_boundary();
    step();
    chk("pend_clr2", {15'd0, pending}, 16'd0);
    bad = 0;
    for (int i = 0; i < 128; i++) begin
      step();
      if (obs_sseg === 7'b1111001) bad++;
    end
    chk("no_1111_shown", bad[15:0], 16'd0);

    // Load on the frame_tick cycle goes straight to display.
    to_boundary();
    chk("tick_now", {15'd0, frame_tick}, 16'd1);
    value = 16'h0008; dp_in = 4'b0000; load = 1'b1;
    step();
    load = 1'b0;
    chk("pend_never", {15'd0, pending}, 16'd0);
    step();
    chk("dig0_8", {9'd0, obs_sseg}, 16'h0000);

    // Decode table, every nibble on every digit.
    for (int i = 0; i < 16; i++) begin
      value = {4{tab[i].nib}}; load = 1'b1;
      step();
      load = 1'b0;
      to_boundary();
      steps(2);
      chk($sformatf("dec_%h", tab[i].nib), {9'd0, obs_sseg}, {9'd0, tab[i].seg});
    end

    // PWM duty and blank.
    bright = 4'd0; clr_counts(); steps(64);
    for (int i = 0; i < 4; i++) chk($sformatf("pwm0_d%0d", i), low_cnt[i][15:0], 16'd1);
    bright = 4'd7; steps(1); clr_counts(); steps(64);
    for (int i = 0; i < 4; i++) chk($sformatf("pwm7_d%0d", i), low_cnt[i][15:0], 16'd8);
    bright = 4'd15; steps(1); clr_counts(); steps(64);
    for (int i = 0; i < 4; i++) chk($sformatf("pwm15_d%0d", i), low_cnt[i][15:0], 16'd16);
    blank = 1'b1; steps(1); clr_counts(); steps(128);
    for (int i = 0; i < 4; i++) chk($sformatf("blank_d%0d", i), low_cnt[i][15:0], 16'd0);
    chk("blank_ticks", ft_cnt[15:0], 16'd2);
    blank = 1'b0;

`ifdef LEADING_ZERO_BLANK_EN
    value = 16'h0070; load = 1'b1; step(); load = 1'b0;
    to_boundary(); steps(2); clr_counts(); steps(64);
    chk("lz70_d3", low_cnt[3][15:0], 16'd0);
    chk("lz70_d2", low_cnt[2][15:0], 16'd0);
    chk("lz70_d1", low_cnt[1][15:0], 16'd16);
    chk("lz70_d0", low_cnt[0][15:0], 16'd16);
    value = 16'h0000; load = 1'b1; step(); load = 1'b0;
    to_boundary(); steps(2); clr_counts(); steps(64);
    chk("lz0_d3", low_cnt[3][15:0], 16'd0);
    chk("lz0_d1", low_cnt[1][15:0], 16'd0);
    chk("lz0_d0", low_cnt[0][15:0], 16'd16);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
